game_countdown_timer: RTL

Per-round countdown timer sitting directly upstream of the game control FSM. It turns the free-running 1 Hz `incrementClk` into single-cycle second ticks in the `clkIn` domain and counts down `GAME_TIME` seconds while the game is active. It asserts `timer_expired` to end the round, and publishes the remaining time in binary and BCD for the seven-segment display path.

---
 rtl/game_pkg.sv | 21 ++
 rtl/tick_sync.sv | 27 ++
 rtl/game_countdown_timer.sv | 93 +++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings and widths for the game timer path.
package game_pkg;

  localparam int unsigned SEC_W = 6;

  typedef enum logic [1:0] {
    TMR_IDLE     = 2'd0,
    TMR_COUNTING = 2'd1,
    TMR_EXPIRED  = 2'd2
  } tmr_state_t;

  // Decimal digit split of a seconds value (valid for 0..63)
  function automatic logic [3:0] bcd_tens(input logic [SEC_W-1:0] v);
    return 4'(v / SEC_W'(10));
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [SEC_W-1:0] v);
    return 4'(v % SEC_W'(10));
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchronizer plus a registered rising-edge pulse for a slow async level.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Per-round countdown timer: turns the 1 Hz input into ticks and counts a round down
// to expiry, publishing the remaining time in binary and BCD.
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int unsigned GAME_TIME = 30,
  parameter int unsigned WARN_TIME = 5
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             incrementClk,
  input  logic             game_active,
  output logic             timer_expired,
  output logic [SEC_W-1:0] seconds_left,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             warn,
  output logic             sec_tick
);

  localparam logic [SEC_W-1:0] LOAD_VAL = SEC_W'(GAME_TIME);
  localparam logic [SEC_W-1:0] WARN_LIM = SEC_W'(WARN_TIME);

  tmr_state_t state;
  logic       act_d;
  logic       start;

  tick_sync u_tick_sync (
    .clk   (clkIn),
    .rst_n (reset),
    .din   (incrementClk),
    .pulse (sec_tick)
  );

  assign start = game_active & ~act_d;

  // State, down-counter and expiry flag; dropping game_active outranks a tick
  always_ff @(posedge clkIn) begin
    if (!reset) begin
      state         <= TMR_IDLE;
      seconds_left  <= LOAD_VAL;
      timer_expired <= 1'b0;
      act_d         <= 1'b0;
    end else begin
      act_d <= game_active;
      case (state)
        TMR_IDLE: begin
          seconds_left  <= LOAD_VAL;
          timer_expired <= 1'b0;
          if (start) begin
            state <= TMR_COUNTING;
          end
        end
        TMR_COUNTING: begin
          if (!game_active) begin
            state         <= TMR_IDLE;
            seconds_left  <= LOAD_VAL;
            timer_expired <= 1'b0;
          end else if (sec_tick) begin
            if (seconds_left > SEC_W'(1)) begin
              seconds_left <= seconds_left - SEC_W'(1);
            end else begin
              seconds_left  <= '0;
              state         <= TMR_EXPIRED;
              timer_expired <= 1'b1;
            end
          end
        end
        TMR_EXPIRED: begin
          if (!game_active) begin
            state         <= TMR_IDLE;
            seconds_left  <= LOAD_VAL;
            timer_expired <= 1'b0;
          end else begin
            seconds_left  <= '0;
            timer_expired <= 1'b1;
          end
        end
        default: begin
          state         <= TMR_IDLE;
          seconds_left  <= LOAD_VAL;
          timer_expired <= 1'b0;
        end
      endcase
    end
  end

  // Display digits and low-time flag follow the counter register with no extra latency
  assign tens = bcd_tens(seconds_left);
  assign ones = bcd_ones(seconds_left);
  assign warn = (state == TMR_COUNTING) && (seconds_left != '0) && (seconds_left <= WARN_LIM);

endmodule
